vote_window_filter: RTL and testbench

//  Front end for the 3-of-4 majority voter stage. Collects a serial bit stream into
//  a 4-sample sliding window and presents the window as the voter's x,y,z,w inputs.

---
 rtl/vote_window_filter.sv | 148 ++++++++++++++
 tb/tb_vote_window_filter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vote_window_filter.sv
// vote_window_filter: 4-sample sliding window feeding the 3-of-4 voter,
// with an internal registered vote and a debounced, change-strobed level.
module vote_window_filter #(
    parameter int unsigned STABLE_COUNT = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic [3:0] window,
    output logic [2:0] fill,
    output logic       vote_valid,
    output logic       vote,
    output logic       filt_out,
    output logic       changed
);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam logic [CNT_W:0] RUN_LIMIT = (CNT_W + 1)'(STABLE_COUNT);
    localparam logic [2:0]     FILL_MAX  = 3'd4;
    localparam logic [2:0]     FILL_VOTE = 3'd3;

    logic [3:0]       window_q, window_d;
    logic [2:0]       fill_q, fill_d;
    logic             vv_q, vv_d;
    logic             vote_q, vote_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             filt_q, filt_d;
    logic             chg_q, chg_d;
    logic [CNT_W:0]   run_inc;
    logic             run_hit;
    logic             take;

    // at-least-3-of-4, x=oldest .. w=newest
    function automatic logic maj4(input logic [3:0] win);
        logic x, y, z, w;
        x = win[3];
        y = win[2];
        z = win[1];
        w = win[0];
        return (x & y & w) | (x & y & z) | (x & z & w) | (y & z & w);
    endfunction

    assign take = in_valid & ~clr;

    // window shift, saturating fill count and registered vote
    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        if (clr) begin
            window_d = '0;
            fill_d   = '0;
        end else if (in_valid) begin
            window_d = {window_q[2:0], in_bit};
            fill_d   = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + 3'd1;
        end
        vv_d   = take & (fill_q >= FILL_VOTE);
        vote_d = vv_d ? maj4(window_d) : vote_q;
    end

    assign run_inc = {1'b0, run_q} + {{CNT_W{1'b0}}, 1'b1};
    assign run_hit = (run_inc == RUN_LIMIT);

    // debounce FSM: a flip needs STABLE_COUNT consecutive disagreeing votes
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        filt_d  = filt_q;
        chg_d   = 1'b0;
        if (clr) begin
            state_d = ST_FILL;
            run_d   = '0;
        end else if (vv_q) begin
            unique case (state_q)
                ST_FILL: begin
                    filt_d  = vote_q;
                    run_d   = '0;
                    state_d = vote_q ? ST_HIGH : ST_LOW;
                end
                ST_LOW: begin
                    if (!vote_q) begin
                        run_d = '0;
                    end else if (run_hit) begin
                        filt_d  = 1'b1;
                        chg_d   = 1'b1;
                        run_d   = '0;
                        state_d = ST_HIGH;
                    end else begin
                        run_d = run_inc[CNT_W-1:0];
                    end
                end
                ST_HIGH: begin
                    if (vote_q) begin
                        run_d = '0;
                    end else if (run_hit) begin
                        filt_d  = 1'b0;
                        chg_d   = 1'b1;
                        run_d   = '0;
                        state_d = ST_LOW;
                    end else begin
                        run_d = run_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    run_d   = '0;
                end
            endcase
        end
    end

    // state registers; reset overrides clr and sampling
    always_ff @(posedge clk) begin
        if (reset) begin
            window_q <= '0;
            fill_q   <= '0;
            vv_q     <= 1'b0;
            vote_q   <= 1'b0;
            state_q  <= ST_FILL;
            run_q    <= '0;
            filt_q   <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            vv_q     <= vv_d;
            vote_q   <= vote_d;
            state_q  <= state_d;
            run_q    <= run_d;
            filt_q   <= filt_d;
            chg_q    <= chg_d;
        end
    end

    assign window     = window_q;
    assign fill       = fill_q;
    assign vote_valid = vv_q;
    assign vote       = vote_q;
    assign filt_out   = filt_q;
    assign changed    = chg_q;

endmodule

// File: tb/tb_vote_window_filter.sv
// tb_vote_window_filter: directed vectors for the window/vote/debounce
// front end, STABLE_COUNT=3.
module tb_vote_window_filter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic [3:0] window;
    logic [2:0] fill;
    logic       vote_valid;
    logic       vote;
    logic       filt_out;
    logic       changed;

    int n_run = 0;
    int n_fail = 0;

    vote_window_filter #(.STABLE_COUNT(3), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .window     (window),
        .fill       (fill),
        .vote_valid (vote_valid),
        .vote       (vote),
        .filt_out   (filt_out),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic b,
                        input logic c, input logic r);
        reset    = r;
        clr      = c;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_win(input string tag, input logic [3:0] w,
                           input logic [2:0] f, input logic vv);
        check({tag, ".window"}, {4'h0, window}, {4'h0, w});
        check({tag, ".fill"}, {5'h0, fill}, {5'h0, f});
        check({tag, ".vv"}, {7'h0, vote_valid}, {7'h0, vv});
    endtask

    task automatic chk_filt(input string tag, input logic f, input logic c);
        check({tag, ".filt"}, {7'h0, filt_out}, {7'h0, f});
        check({tag, ".chg"}, {7'h0, changed}, {7'h0, c});
    endtask

    task automatic chk_vote(input string tag, input logic v);
        check({tag, ".vv"}, {7'h0, vote_valid}, 8'h1);
        check({tag, ".vote"}, {7'h0, vote}, {7'h0, v});
    endtask

    task automatic chk_zero(input string tag);
        chk_win(tag, 4'h0, 3'd0, 1'b0);
        check({tag, ".vote"}, {7'h0, vote}, 8'h0);
        chk_filt(tag, 1'b0, 1'b0);
    endtask

    logic [3:0] tbl_win[6] = '{4'b0011, 4'b0111, 4'b1110,
                               4'b1010, 4'b1111, 4'b1011};
    logic       tbl_vote[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    logic [7:0] t4_bits = 8'b0101_1000;
    logic [7:0] t4_vote = 8'b1100_1000;

    initial begin
        // reset dominates a valid sample
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_zero("rst");

        // first fill: 1,1,0,1
        push(1'b1);
        chk_win("f1", 4'b0001, 3'd1, 1'b0);
        push(1'b1);
        chk_win("f2", 4'b0011, 3'd2, 1'b0);
        push(1'b0);
        chk_win("f3", 4'b0110, 3'd3, 1'b0);
        push(1'b1);
        chk_win("f4", 4'b1101, 3'd4, 1'b1);
        check("f4.vote", {7'h0, vote}, 8'h1);
        idle();
        chk_filt("f5", 1'b1, 1'b0);
        check("f5.vv", {7'h0, vote_valid}, 8'h0);
        check("f5.vhold", {7'h0, vote}, 8'h1);

        // vote table, each window loaded fresh after a flush
        for (int i = 0; i < 6; i++) begin
            logic [3:0] w;
            w = tbl_win[i];
            step(1'b1, 1'b1, 1'b1, 1'b0);
            chk_win($sformatf("tbl%0d.clr", i), 4'h0, 3'd0, 1'b0);
            for (int k = 3; k >= 0; k--) push(w[k]);
            chk_win($sformatf("tbl%0d", i), w, 3'd4, 1'b1);
            check($sformatf("tbl%0d.vote", i), {7'h0, vote},
                  {7'h0, tbl_vote[i]});
            idle();
            chk_filt($sformatf("tbl%0d.out", i), tbl_vote[i], 1'b0);
        end

        // flush with a sample offered: dropped, level held
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_win("clr", 4'h0, 3'd0, 1'b0);
        chk_filt("clr", 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            push(1'b1);
            chk_win($sformatf("clr.r%0d", k), 4'b1111 >> (4 - k),
                    3'(k), 1'b0);
        end
        push(1'b1);
        chk_vote("clr.r4", 1'b1);
        idle();
        chk_filt("clr.out", 1'b1, 1'b0);

        // debounce high->low: votes 1,1 then 0,0,1,0,0,0
        for (int k = 7; k >= 0; k--) begin
            push(t4_bits[k]);
            chk_vote($sformatf("db%0d", 7 - k), t4_vote[k]);
            chk_filt($sformatf("db%0d", 7 - k), 1'b1, 1'b0);
        end
        idle();
        chk_filt("db.flip", 1'b0, 1'b1);
        idle();
        chk_filt("db.after", 1'b0, 1'b0);

        // gaps hold window and run count (LOW, run=1)
        push(1'b1);
        push(1'b1);
        push(1'b1);
        chk_vote("gap.v", 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk_win($sformatf("gap%0d", k), 4'b0111, 3'd4, 1'b0);
            chk_filt($sformatf("gap%0d", k), 1'b0, 1'b0);
        end
        push(1'b1);
        idle();
        chk_filt("gap.r2", 1'b0, 1'b0);
        push(1'b1);
        idle();
        chk_filt("gap.flip", 1'b1, 1'b1);

        // reset mid-run: HIGH with run=2
        push(1'b0);
        push(1'b0);
        push(1'b0);
        chk_vote("mid.v", 1'b0);
        idle();
        chk_filt("mid.r2", 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_zero("mid.rst");

        // after reset: first decision comes from FILL, run starts at 0
        push(1'b1);
        push(1'b1);
        push(1'b1);
        push(1'b0);
        chk_win("post", 4'b1110, 3'd4, 1'b1);
        check("post.vote", {7'h0, vote}, 8'h1);
        idle();
        chk_filt("post.fill", 1'b1, 1'b0);
        push(1'b0);
        chk_vote("post.v0", 1'b0);
        idle();
        chk_filt("post.run", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
